// File: rtl/spi_master_sck_gen_pkg.sv
// Shared definitions for the SPI master sck/cs timing generator.
// Holds the FSM state encoding and the counter-width helper that the
// slave-side edge detector also uses.
package spi_master_sck_gen_pkg;

  localparam int unsigned STATE_W = 3;

  // Transfer sequencing states
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_CLOCKING = 3'd2,
    ST_HOLD     = 3'd3,
    ST_GAP      = 3'd4
  } spi_state_e;

  // Width of a counter holding 0..n-1; never narrower than one bit
  function automatic int unsigned calc_bit_cnt_w(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/spi_master_sck_gen_div_tick.sv
// spi_div_tick: free-running modulo-CLK_DIV counter with synchronous clear.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr_i       forces the counter back to 0 on the next edge
//   tick_c_o    combinational, high in the last cycle of each CLK_DIV window
module spi_div_tick
  import spi_master_sck_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = calc_bit_cnt_w(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c_o = (cnt_q == CNT_W'(CLK_DIV - 1));

  // Wrap on tick, restart on clear
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_c_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_sck_gen.sv
// spi_master_sck_gen: SPI master-side cs/sck timing generator.
// One fixed-length transfer of DATA_WIDTH sck cycles per accepted start,
// with per-edge and per-transfer strobes for an external shifter.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   cpol_i              sck idle level, latched when a start is accepted
//   start_i             transfer request, honoured only while not busy
//   busy_o              transfer in progress (including the trailing gap)
//   cs_o, sck_o         chip select (active low) and serial clock
//   sck_first_edge_o    strobe: sck just left its idle level
//   sck_second_edge_o   strobe: sck just returned to its idle level
//   spi_start_o         strobe: first cycle of the cs-low window
//   spi_finish_o        strobe: first cycle cs is high again
//   bit_cnt_o           index of the bit in progress
module spi_master_sck_gen
  import spi_master_sck_gen_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned CLK_DIV    = 4,
  localparam int unsigned BIT_CNT_W  = calc_bit_cnt_w(DATA_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpol_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 cs_o,
  output logic                 sck_o,
  output logic                 sck_first_edge_o,
  output logic                 sck_second_edge_o,
  output logic                 spi_start_o,
  output logic                 spi_finish_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o
);

  spi_state_e           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 cs_q, cs_d;
  logic                 sck_q, sck_d;
  logic                 first_q, first_d;
  logic                 second_q, second_d;
  logic                 start_q, start_d;
  logic                 finish_q, finish_d;
  logic                 cpol_q, cpol_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic                 div_clr_c;
  logic                 tick_c;

  // Divider restarts whenever the FSM moves, so every state lasts whole windows
  assign div_clr_c = (state_d != state_q);

  spi_div_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (div_clr_c),
    .tick_c_o (tick_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    first_d   = 1'b0;
    second_d  = 1'b0;
    start_d   = 1'b0;
    finish_d  = 1'b0;
    cpol_d    = cpol_q;
    bit_cnt_d = bit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        sck_d = cpol_i;
        if (start_i) begin
          state_d   = ST_SETUP;
          cpol_d    = cpol_i;
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          start_d   = 1'b1;
          bit_cnt_d = '0;
        end
      end

      // The setup tick launches the first edge directly
      ST_SETUP: begin
        if (tick_c) begin
          state_d = ST_CLOCKING;
          sck_d   = ~cpol_q;
          first_d = 1'b1;
        end
      end

      // sck level tells which edge comes next; the last second edge ends clocking
      ST_CLOCKING: begin
        if (tick_c) begin
          if (sck_q == cpol_q) begin
            sck_d   = ~cpol_q;
            first_d = 1'b1;
          end else begin
            sck_d    = cpol_q;
            second_d = 1'b1;
            if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
              bit_cnt_d = '0;
              state_d   = ST_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
      end

      ST_HOLD: begin
        if (tick_c) begin
          state_d  = ST_GAP;
          cs_d     = 1'b1;
          finish_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (tick_c) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      first_q   <= 1'b0;
      second_q  <= 1'b0;
      start_q   <= 1'b0;
      finish_q  <= 1'b0;
      cpol_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      first_q   <= first_d;
      second_q  <= second_d;
      start_q   <= start_d;
      finish_q  <= finish_d;
      cpol_q    <= cpol_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign busy_o            = busy_q;
  assign cs_o              = cs_q;
  assign sck_o             = sck_q;
  assign sck_first_edge_o  = first_q;
  assign sck_second_edge_o = second_q;
  assign spi_start_o       = start_q;
  assign spi_finish_o      = finish_q;
  assign bit_cnt_o         = bit_cnt_q;

endmodule

// File: doc/spi_master_sck_gen.md
Name: spi_master_sck_gen

Overview:
SPI master-side timing generator. It drives cs and sck for one fixed-length transfer per start request and supports both clock polarities. It emits one-cycle strobes on every sck edge, plus transfer start and finish strobes, so a master shifter can launch and sample data. It is the counterpart of the slave-side sck/cs edge detector and uses the same edge and strobe semantics.

Parameters:
DATA_WIDTH, 8, bits per transfer; number of sck cycles per cs-low window (min 1)
CLK_DIV, 4, clk cycles per sck half-period (min 1; CLK_DIV=1 gives sck = clk/2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous reset, active low
cpol  input  1  sck idle level; tracked while idle, latched when a start is accepted
start  input  1  transfer request; sampled only while busy=0
busy  output  1  high from the cycle after start is accepted until the inter-transfer gap ends
cs  output  1  chip select, active low, registered
sck  output  1  serial clock, registered
sck_first_edge  output  1  one-cycle strobe in the cycle sck leaves its idle level
sck_second_edge  output  1  one-cycle strobe in the cycle sck returns to its idle level
spi_start  output  1  one-cycle strobe in the first cycle cs is low
spi_finish  output  1  one-cycle strobe in the first cycle cs is high again
bit_cnt  output  $clog2(DATA_WIDTH) (min 1)  index of the bit in progress; 0 at start, +1 after each second edge

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - outputs: cs=1, sck=0, busy=0, all strobes 0, bit_cnt=0
  - state: state=IDLE, divider counter=0, latched cpol=0
- States: IDLE -> SETUP -> CLOCKING -> HOLD -> GAP -> IDLE.
- Divider: counter 0..CLK_DIV-1, cleared on every state change. A "tick" is the cycle where counter==CLK_DIV-1.
- IDLE:
  - cs=1; sck follows cpol with one cycle of register latency.
  - start=1 at rising edge T: latch cpol, go to SETUP. At T+1: cs=0, busy=1, spi_start=1.
- SETUP: CLK_DIV cycles with sck held at the latched idle level; on the tick go to CLOCKING.
- CLOCKING:
  - sck toggles on each tick, giving 2*DATA_WIDTH toggles.
  - The first edge is visible at T+1+CLK_DIV; later edges follow every CLK_DIV cycles.
  - Toggle to the non-idle level: sck_first_edge=1 in the same cycle the new sck value appears.
  - Toggle back to idle: sck_second_edge=1 in that cycle, and bit_cnt increments. On the last second edge bit_cnt wraps to 0.
  - Last edge at T+1+CLK_DIV*2*DATA_WIDTH, then go to HOLD.
- HOLD: CLK_DIV cycles with sck idle and cs low. On the tick: cs=1 and spi_finish=1 at T+1+CLK_DIV*(2*DATA_WIDTH+1); go to GAP.
- GAP: CLK_DIV cycles with cs high; busy drops on exit. First busy=0 cycle is T+1+CLK_DIV*(2*DATA_WIDTH+2).
- cs low window is exactly CLK_DIV*(2*DATA_WIDTH+1) cycles. sck is never at its active level while cs=1.
- Ignored while busy: start, and cpol changes. No queuing of requests.
- start held high: back-to-back transfers. Next start is accepted in the first busy=0 cycle, so the transfer period is CLK_DIV*(2*DATA_WIDTH+2)+1 cycles.
- Strobes are mutually exclusive except spi_start, which never coincides with an sck edge strobe.
- With cpol=0, first_edge is the rising sck edge; with cpol=1 it is the falling edge (same meaning as on the slave side).

Decomposition:
- Shared package:
  - state encoding localparams (IDLE, SETUP, CLOCKING, HOLD, GAP)
  - BIT_CNT_W derivation helper, shared with the slave block
- One natural sub-module: spi_div_tick. It is a CLK_DIV divider with synchronous clear and a tick output.

Test Plan:
- cpol=0, DATA_WIDTH=8, CLK_DIV=4, start pulse at cycle 10:
  - cs low in cycles 11..78 (68 cycles); spi_start at 11
  - first sck rise at 15; 8 first_edge and 8 second_edge strobes, 4 cycles apart
  - spi_finish at 79; busy low at 83
- cpol=1, same settings: sck idles high; first_edge coincides with sck 1->0; bit_cnt reads 0..7 then 0; sck=1 whenever cs=1.
- CLK_DIV=1, DATA_WIDTH=4: sck toggles every cycle (16 toggles are not expected; exactly 8 toggles); cs low for 9 cycles.
- start held high for 3 transfers (DATA_WIDTH=8, CLK_DIV=4): spi_start strobes 73 cycles apart; cs high for exactly 5 cycles between windows.
- start pulses and cpol toggles while busy=1: no effect on the sck waveform, strobe count or cs timing.
- rst_n asserted at cycle 30 mid-CLOCKING: cs=1, sck=0, busy=0 and strobes 0 immediately (asynchronous); a start after release produces a full, clean transfer.
